bt_cmd_decoder: RTL and testbench
=================================

# bt_cmd_decoder

Byte-level command parser sitting directly downstream of the Bluetooth UART receiver. It consumes each received byte (`rx_data` qualified by the `rx_done` strobe) and assembles 4-byte frames. It checks each frame and commits valid commands to registered hovercraft control outputs (thrust, steering angle, lift fan). A link watchdog forces the craft to a safe state when valid frames stop arriving.

## Interface
Parameters:
- `GAP_CYCLES`, 1_000_000: maximum clock cycles between bytes of one frame (10 ms at 100 MHz).
- `WDOG_CYCLES`, 100_000_000: maximum cycles between valid frames before failsafe (1 s at 100 MHz).

Ports:
- `Clk`  in  1  system clock, 100 MHz. Single clock domain.
- `Rst`  in  1  reset. Synchronous and active-high.
- `rx_data`  in  8  received byte. Valid only when `rx_done` = 1.
- `rx_done`  in  1  one-cycle strobe; exactly one byte per strobe.
- `thrust`  out  8  propulsion duty, 0..255.
- `steer`  out  8  servo angle in degrees, 0..180.
- `lift_on`  out  1  lift fan enable.
- `cmd_strobe`  out  1  one-cycle pulse when a frame is committed.
- `link_alive`  out  1  high while the watchdog has not expired.
- `err_cnt`  out  8  saturating count of rejected frames.

## Operation
Frame format: `0xAA`, CMD, VAL, CHK, where CHK = CMD ^ VAL.

Commands:
- `0x01` sets `thrust` = VAL.
- `0x02` sets `steer` = min(VAL, 180).
- `0x03` sets `lift_on` = VAL[0].
- `0x04` is STOP: `thrust` = 0, `lift_on` = 0, `steer` = 90. VAL is ignored but still covered by CHK.

FSM states: IDLE, CMD, VAL, CHK. All transitions occur only on `rx_done`, except gap-timeout and reset.
- IDLE: byte `0xAA` moves to CMD. Any other byte is discarded silently (no error).
- CMD: byte `0xAA` stays in CMD as a re-sync (no error). Any other byte is latched as CMD and moves to VAL.
- VAL: any byte is latched as VAL and moves to CHK.
- CHK: always returns to IDLE. The frame is rejected if CHK mismatches or CMD is not in {01..04}.
- Rejected frame: `err_cnt` += 1, saturating at 255. No outputs change.
- Gap timeout: in CMD/VAL/CHK, if `GAP_CYCLES` elapse with no `rx_done`, go to IDLE and increment `err_cnt`. The gap counter reloads on every `rx_done`.

Watchdog:
- Counter reloads on every committed frame.
- On expiry: `link_alive` = 0, `thrust` = 0, `lift_on` = 0. `steer` is held.
- The next committed frame sets `link_alive` = 1 and applies its command.
- Apart from that command, thrust and lift stay 0 until explicitly set.

## Timing
- Reset values: `thrust` = 0, `steer` = 90, `lift_on` = 0, `cmd_strobe` = 0, `link_alive` = 0, `err_cnt` = 0, FSM = IDLE. Both counters cleared/reloaded.
- `link_alive` stays 0 after reset until the first committed frame.
- Commit latency: outputs and `cmd_strobe` update on the clock edge after the cycle in which CHK's `rx_done` is sampled (1 cycle).
- `cmd_strobe` is high for exactly one cycle per committed frame.
- Simultaneous events:
  - `rx_done` in the same cycle as gap expiry: the byte wins, and no timeout error is counted.
  - Commit in the same cycle as watchdog expiry: the commit wins, `link_alive` stays 1, and the counter reloads.
- Back-to-back `rx_done` on consecutive cycles must be accepted (no dead cycles).
- `Rst` asserted mid-frame: the partial frame is dropped, there is no error increment, and all outputs return to reset values on the next edge.

## Structure
- Package `bt_cmd_pkg`:
  - Constants: `HDR` = 8'hAA; command codes `CMD_THRUST`/`CMD_STEER`/`CMD_LIFT`/`CMD_STOP`; `STEER_CENTER` = 90; `STEER_MAX` = 180.
  - FSM state enum.
- Sub-module `cycle_timer`:
  - Parameterised down-counter with `load` and `expired` outputs.
  - Instantiated twice, once for the byte gap and once for the watchdog.
  - `expired` is a one-cycle pulse on reaching zero; the counter holds at zero afterwards until reloaded.

## Test plan
- Reset, then send AA 01 80 81 -> `thrust` = 0x80; `cmd_strobe` is a 1-cycle pulse one cycle after the last `rx_done`; `link_alive` = 1.
- Send AA 02 C8 CA (VAL = 200) -> `steer` = 180. Then send AA 04 00 04 -> `thrust` = 0, `lift_on` = 0, `steer` = 90.
- Bad checksum AA 03 01 00, then unknown command AA 07 00 07 -> no output change, no strobe, `err_cnt` = 2. Force 256 more errors -> `err_cnt` holds at 255.
- AA AA AA 03 01 02 -> `lift_on` = 1 (re-sync), `err_cnt` unchanged. Also AA 01 followed by a stall of `GAP_CYCLES` -> FSM in IDLE, `err_cnt` += 1.
- Set `thrust` = 0x80 and `lift_on` = 1, then go idle for `WDOG_CYCLES` (reduced to 1000 in the bench) -> `link_alive` = 0, `thrust` = 0, `lift_on` = 0, `steer` held. Then a frame that lands exactly on the expiry cycle -> committed, `link_alive` = 1.
- Assert `Rst` after AA 01 -> FSM in IDLE, all outputs at reset values. A following complete frame is decoded correctly.

Source files
------------

// File: rtl/bt_cmd_pkg.sv
// Shared constants, FSM state type and command-code helper for the Bluetooth
// hovercraft command decoder.
package bt_cmd_pkg;

    localparam logic [7:0] HDR          = 8'hAA;
    localparam logic [7:0] CMD_THRUST   = 8'h01;
    localparam logic [7:0] CMD_STEER    = 8'h02;
    localparam logic [7:0] CMD_LIFT     = 8'h03;
    localparam logic [7:0] CMD_STOP     = 8'h04;
    localparam logic [7:0] STEER_CENTER = 8'd90;
    localparam logic [7:0] STEER_MAX    = 8'd180;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_VAL,
        ST_CHK
    } state_t;

    function automatic logic cmd_known(input logic [7:0] cmd);
        return (cmd >= CMD_THRUST) && (cmd <= CMD_STOP);
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Reloadable down-counter; expired is high during the last counting cycle,
// i.e. the cycle whose closing edge brings the count to zero. CYCLES >= 1.
module cycle_timer #(
    parameter int unsigned CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expired
);

    localparam int unsigned W = $clog2(CYCLES + 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            r_cnt <= W'(CYCLES);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Counter holds at zero afterwards, so this is a single-cycle pulse.
    assign expired = (r_cnt == W'(1));

endmodule

// File: rtl/bt_cmd_decoder.sv
// Parses AA/CMD/VAL/CHK frames from the UART byte stream into registered
// hovercraft controls, with inter-byte gap timeout and link watchdog.
module bt_cmd_decoder
    import bt_cmd_pkg::*;
#(
    parameter int unsigned GAP_CYCLES  = 1_000_000,
    parameter int unsigned WDOG_CYCLES = 100_000_000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic [7:0] thrust,
    output logic [7:0] steer,
    output logic       lift_on,
    output logic       cmd_strobe,
    output logic       link_alive,
    output logic [7:0] err_cnt
);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_cmd;
    logic [7:0] r_val;
    logic       w_gap_exp;
    logic       w_wdog_exp;
    logic       w_frame_done;
    logic       w_commit;
    logic       w_gap_timeout;
    logic       w_err_inc;

    assign w_frame_done  = (r_state == ST_CHK) && rx_done;
    assign w_commit      = w_frame_done && (rx_data == (r_cmd ^ r_val)) && cmd_known(r_cmd);
    // A byte arriving on the expiry cycle takes precedence over the timeout.
    assign w_gap_timeout = (r_state != ST_IDLE) && !rx_done && w_gap_exp;
    assign w_err_inc     = (w_frame_done && !w_commit) || w_gap_timeout;

    cycle_timer #(.CYCLES(GAP_CYCLES)) u_gap_timer (
        .clk     (Clk),
        .rst     (Rst),
        .load    (rx_done),
        .expired (w_gap_exp)
    );

    cycle_timer #(.CYCLES(WDOG_CYCLES)) u_wdog_timer (
        .clk     (Clk),
        .rst     (Rst),
        .load    (w_commit),
        .expired (w_wdog_exp)
    );

    always_comb begin
        w_state_next = r_state;
        if (rx_done) begin
            case (r_state)
                ST_IDLE: if (rx_data == HDR) w_state_next = ST_CMD;
                ST_CMD:  if (rx_data != HDR) w_state_next = ST_VAL;
                ST_VAL:  w_state_next = ST_CHK;
                ST_CHK:  w_state_next = ST_IDLE;
                default: w_state_next = ST_IDLE;
            endcase
        end else if (w_gap_timeout) begin
            w_state_next = ST_IDLE;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= ST_IDLE;
            r_cmd   <= '0;
            r_val   <= '0;
        end else begin
            r_state <= w_state_next;
            if (rx_done && (r_state == ST_CMD) && (rx_data != HDR)) r_cmd <= rx_data;
            if (rx_done && (r_state == ST_VAL)) r_val <= rx_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            thrust     <= '0;
            steer      <= STEER_CENTER;
            lift_on    <= 1'b0;
            cmd_strobe <= 1'b0;
            link_alive <= 1'b0;
            err_cnt    <= '0;
        end else begin
            cmd_strobe <= w_commit;
            if (w_err_inc && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
            // Commit beats a coincident watchdog expiry.
            if (w_commit) begin
                link_alive <= 1'b1;
                case (r_cmd)
                    CMD_THRUST: thrust  <= r_val;
                    CMD_STEER:  steer   <= (r_val > STEER_MAX) ? STEER_MAX : r_val;
                    CMD_LIFT:   lift_on <= r_val[0];
                    CMD_STOP: begin
                        thrust  <= '0;
                        lift_on <= 1'b0;
                        steer   <= STEER_CENTER;
                    end
                    default: ;
                endcase
            end else if (w_wdog_exp) begin
                link_alive <= 1'b0;
                thrust     <= '0;
                lift_on    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bt_cmd_decoder.sv
// Self-checking bench for bt_cmd_decoder: frame vector table plus hand-built
// sequences for gap/watchdog boundaries, error saturation and mid-frame reset.
`timescale 1ns/1ps
module tb_bt_cmd_decoder;

    localparam int unsigned GAP  = 40;
    localparam int unsigned WDOG = 1000;
    localparam int          NV   = 20;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] thrust;
    logic [7:0] steer;
    logic       lift_on;
    logic       cmd_strobe;
    logic       link_alive;
    logic [7:0] err_cnt;

    always #5 Clk = ~Clk;

    bt_cmd_decoder #(
        .GAP_CYCLES  (GAP),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .thrust     (thrust),
        .steer      (steer),
        .lift_on    (lift_on),
        .cmd_strobe (cmd_strobe),
        .link_alive (link_alive),
        .err_cnt    (err_cnt)
    );

    typedef struct packed {
        logic [7:0] thr;
        logic [7:0] str;
        logic       lift;
        logic       alive;
    } exp_t;

    typedef struct {
        logic [31:0] frame;
        bit          commit;
        logic [7:0]  thr;
        logic [7:0]  str;
        logic        lift;
        logic [7:0]  err;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[NV];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic prev_strobe = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every commit strobe must match the oldest expected result.
    always @(negedge Clk) begin
        exp_t e;
        if (cmd_strobe === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_strobe: got strobe with no commit expected (thrust 0x%0h)", thrust);
            end else begin
                e = sb_q.pop_front();
                check("commit", 32'({thrust, steer, lift_on, link_alive}), 32'(e));
            end
            if (prev_strobe === 1'b1) begin
                n_tests++;
                n_fail++;
                $display("FAIL strobe_width: got strobe high 2 cycles, expected 1");
            end
        end
        prev_strobe = cmd_strobe;
    end

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge Clk);
        rx_done = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] f);
        for (int i = 0; i < 4; i++) send_byte(f[31-8*i -: 8]);
    endtask

    task automatic expect_commit(input logic [7:0] thr, input logic [7:0] str, input logic lift);
        sb_q.push_back(exp_t'{thr, str, lift, 1'b1});
    endtask

    task automatic check_state(input string tag, input logic [7:0] thr, input logic [7:0] str,
                               input logic lift, input logic alive, input logic [7:0] err);
        check({tag, "_thrust"},  32'(thrust),     32'(thr));
        check({tag, "_steer"},   32'(steer),      32'(str));
        check({tag, "_lift"},    32'(lift_on),    32'(lift));
        check({tag, "_alive"},   32'(link_alive), 32'(alive));
        check({tag, "_err"},     32'(err_cnt),    32'(err));
        check({tag, "_pending"}, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{32'hAA02C8CA, 1'b1, 8'h80, 8'hB4, 1'b0, 8'd0};
        tbl[1]  = '{32'hAA040004, 1'b1, 8'h00, 8'h5A, 1'b0, 8'd0};
        tbl[2]  = '{32'hAA030100, 1'b0, 8'h00, 8'h5A, 1'b0, 8'd1};
        tbl[3]  = '{32'hAA070007, 1'b0, 8'h00, 8'h5A, 1'b0, 8'd2};
        tbl[4]  = '{32'hAA030102, 1'b1, 8'h00, 8'h5A, 1'b1, 8'd2};
        tbl[5]  = '{32'hAA014041, 1'b1, 8'h40, 8'h5A, 1'b1, 8'd2};
        tbl[6]  = '{32'hAA020A08, 1'b1, 8'h40, 8'h0A, 1'b1, 8'd2};
        tbl[7]  = '{32'hAA02B5B7, 1'b1, 8'h40, 8'hB4, 1'b1, 8'd2};
        tbl[8]  = '{32'hAA025A58, 1'b1, 8'h40, 8'h5A, 1'b1, 8'd2};
        tbl[9]  = '{32'hAA02FFFD, 1'b1, 8'h40, 8'hB4, 1'b1, 8'd2};
        tbl[10] = '{32'hAA020A08, 1'b1, 8'h40, 8'h0A, 1'b1, 8'd2};
        tbl[11] = '{32'hAA02B4B6, 1'b1, 8'h40, 8'hB4, 1'b1, 8'd2};
        tbl[12] = '{32'hAA000000, 1'b0, 8'h40, 8'hB4, 1'b1, 8'd3};
        tbl[13] = '{32'hAA050005, 1'b0, 8'h40, 8'hB4, 1'b1, 8'd4};
        tbl[14] = '{32'hAA03FEFD, 1'b1, 8'h40, 8'hB4, 1'b0, 8'd4};
        tbl[15] = '{32'hAA01FFFE, 1'b1, 8'hFF, 8'hB4, 1'b0, 8'd4};
        tbl[16] = '{32'hAA04FFFB, 1'b1, 8'h00, 8'h5A, 1'b0, 8'd4};
        tbl[17] = '{32'hAA0401FF, 1'b0, 8'h00, 8'h5A, 1'b0, 8'd5};
        tbl[18] = '{32'hAA03FF00, 1'b0, 8'h00, 8'h5A, 1'b0, 8'd6};
        tbl[19] = '{32'hAA01AAAB, 1'b1, 8'hAA, 8'h5A, 1'b0, 8'd6};

        Rst     = 1'b1;
        rx_done = 1'b0;
        rx_data = 8'h00;
        idle(2);
        Rst = 1'b0;
        check("reset_strobe", 32'(cmd_strobe), 32'd0);
        check_state("reset", 8'h00, 8'h5A, 1'b0, 1'b0, 8'd0);

        // First frame: strobe timing and link coming up.
        expect_commit(8'h80, 8'h5A, 1'b0);
        send_frame(32'hAA018081);
        check("t1_strobe_hi", 32'(cmd_strobe), 32'd1);
        idle(1);
        check("t1_strobe_lo", 32'(cmd_strobe), 32'd0);
        idle(1);
        check_state("t1", 8'h80, 8'h5A, 1'b0, 1'b1, 8'd0);

        for (int i = 0; i < NV; i++) begin
            if (tbl[i].commit) expect_commit(tbl[i].thr, tbl[i].str, tbl[i].lift);
            send_frame(tbl[i].frame);
            idle(2);
            check_state($sformatf("vec%0d", i), tbl[i].thr, tbl[i].str, tbl[i].lift, 1'b1, tbl[i].err);
        end

        // Idle garbage, then repeated headers re-syncing.
        send_byte(8'h55);
        send_byte(8'h12);
        expect_commit(8'hAA, 8'h5A, 1'b1);
        send_byte(8'hAA);
        send_byte(8'hAA);
        send_frame(32'hAA030102);
        idle(2);
        check_state("resync", 8'hAA, 8'h5A, 1'b1, 1'b1, 8'd6);

        // Byte arriving exactly on the gap-expiry cycle is accepted.
        expect_commit(8'h20, 8'h5A, 1'b1);
        send_byte(8'hAA);
        send_byte(8'h01);
        idle(GAP - 1);
        send_byte(8'h20);
        send_byte(8'h21);
        idle(2);
        check_state("gap_edge", 8'h20, 8'h5A, 1'b1, 1'b1, 8'd6);

        // One cycle later the frame is abandoned; trailing bytes are idle garbage.
        send_byte(8'hAA);
        send_byte(8'h01);
        idle(GAP);
        send_byte(8'h30);
        send_byte(8'h31);
        idle(2);
        check_state("gap_tmo", 8'h20, 8'h5A, 1'b1, 1'b1, 8'd7);
        expect_commit(8'h40, 8'h5A, 1'b1);
        send_frame(32'hAA014041);
        idle(2);
        check_state("gap_after", 8'h40, 8'h5A, 1'b1, 1'b1, 8'd7);

        // Watchdog expiry boundary.
        expect_commit(8'h40, 8'h1E, 1'b1);
        send_frame(32'hAA021E1C);
        expect_commit(8'h80, 8'h1E, 1'b1);
        send_frame(32'hAA018081);
        expect_commit(8'h80, 8'h1E, 1'b1);
        send_frame(32'hAA030102);
        idle(WDOG - 1);
        check_state("wdog_pre", 8'h80, 8'h1E, 1'b1, 1'b1, 8'd7);
        idle(1);
        check_state("wdog_exp", 8'h00, 8'h1E, 1'b0, 1'b0, 8'd7);

        // Recovery applies only its own command; then a commit on the expiry cycle.
        expect_commit(8'h10, 8'h1E, 1'b0);
        send_frame(32'hAA011011);
        idle(WDOG - 4);
        expect_commit(8'h10, 8'h1E, 1'b1);
        send_frame(32'hAA030102);
        idle(WDOG - 1);
        check_state("wdog_reload", 8'h10, 8'h1E, 1'b1, 1'b1, 8'd7);
        idle(1);
        check_state("wdog_exp2", 8'h00, 8'h1E, 1'b0, 1'b0, 8'd7);

        // Error counter saturation.
        repeat (247) send_frame(32'hAA010000);
        idle(2);
        check("err_254", 32'(err_cnt), 32'd254);
        send_frame(32'hAA010000);
        idle(2);
        check("err_255", 32'(err_cnt), 32'd255);
        repeat (4) send_frame(32'hAA010000);
        idle(2);
        check_state("err_sat", 8'h00, 8'h1E, 1'b0, 1'b0, 8'd255);

        // Reset in the middle of a frame.
        send_byte(8'hAA);
        send_byte(8'h01);
        Rst = 1'b1;
        idle(1);
        Rst = 1'b0;
        check("rst_strobe", 32'(cmd_strobe), 32'd0);
        check_state("rst_mid", 8'h00, 8'h5A, 1'b0, 1'b0, 8'd0);
        expect_commit(8'h80, 8'h5A, 1'b0);
        send_frame(32'hAA018081);
        idle(2);
        check_state("rst_after", 8'h80, 8'h5A, 1'b0, 1'b1, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
